// File: rtl/mem_port_arbiter.sv
// Two-master, one-slave arbiter for the req/gnt/rvalid memory protocol.
// Round-robin choice, held while the slave stalls; an in-order ID FIFO routes each response back.
module mem_port_arbiter #(
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic                    clk_i,
  input  logic                    rst_i,

  input  logic                    m0_req_i,
  input  logic [ADDR_WIDTH-1:0]   m0_addr_i,
  input  logic                    m0_we_i,
  input  logic [DATA_WIDTH/8-1:0] m0_be_i,
  input  logic [DATA_WIDTH-1:0]   m0_wdata_i,
  output logic                    m0_gnt_o,
  output logic                    m0_rvalid_o,
  output logic [DATA_WIDTH-1:0]   m0_rdata_o,

  input  logic                    m1_req_i,
  input  logic [ADDR_WIDTH-1:0]   m1_addr_i,
  input  logic                    m1_we_i,
  input  logic [DATA_WIDTH/8-1:0] m1_be_i,
  input  logic [DATA_WIDTH-1:0]   m1_wdata_i,
  output logic                    m1_gnt_o,
  output logic                    m1_rvalid_o,
  output logic [DATA_WIDTH-1:0]   m1_rdata_o,

  output logic                    slv_req_o,
  output logic [ADDR_WIDTH-1:0]   slv_addr_o,
  output logic                    slv_we_o,
  output logic [DATA_WIDTH/8-1:0] slv_be_o,
  output logic [DATA_WIDTH-1:0]   slv_wdata_o,
  input  logic                    slv_gnt_i,
  input  logic                    slv_rvalid_i,
  input  logic [DATA_WIDTH-1:0]   slv_rdata_i,

  output logic                    err_o
);

  localparam int BE_WIDTH = DATA_WIDTH / 8;
  localparam int PTR_W    = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int CNT_W    = $clog2(MAX_OUTSTANDING + 1);

  logic                       last_q;
  logic                       lock_q;
  logic                       lock_id_q;
  logic                       err_q;
  logic [MAX_OUTSTANDING-1:0] id_mem;
  logic [PTR_W-1:0]           rd_ptr_q;
  logic [PTR_W-1:0]           wr_ptr_q;
  logic [CNT_W-1:0]           count_q;

  logic winner;
  logic full;
  logic empty;
  logic head;
  logic handshake;
  logic pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full  = (count_q == CNT_W'(MAX_OUTSTANDING));
  assign empty = (count_q == '0);
  assign head  = id_mem[rd_ptr_q];

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    winner = ~last_q;
    if (lock_q) begin
      winner = lock_id_q;
    end else if (m0_req_i && !m1_req_i) begin
      winner = 1'b0;
    end else if (m1_req_i && !m0_req_i) begin
      winner = 1'b1;
    end
  end

  // The full check depends only on registered count, so slv_rvalid_i never reaches slv_req_o.
  assign slv_req_o = (m0_req_i | m1_req_i) & ~full;
  assign handshake = slv_req_o & slv_gnt_i;
  assign pop       = slv_rvalid_i & ~empty;

  always_comb begin
    slv_addr_o  = '0;
    slv_we_o    = 1'b0;
    slv_be_o    = '0;
    slv_wdata_o = '0;
    if (slv_req_o) begin
      if (winner) begin
        slv_addr_o  = m1_addr_i;
        slv_we_o    = m1_we_i;
        slv_be_o    = m1_be_i;
        slv_wdata_o = m1_wdata_i;
      end else begin
        slv_addr_o  = m0_addr_i;
        slv_we_o    = m0_we_i;
        slv_be_o    = m0_be_i;
        slv_wdata_o = m0_wdata_i;
      end
    end
  end

  assign m0_gnt_o    = handshake & ~winner;
  assign m1_gnt_o    = handshake &  winner;
  assign m0_rvalid_o = pop & ~head;
  assign m1_rvalid_o = pop &  head;
  assign m0_rdata_o  = slv_rdata_i;
  assign m1_rdata_o  = slv_rdata_i;
  assign err_o       = err_q;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      last_q    <= 1'b1;
      lock_q    <= 1'b0;
      lock_id_q <= 1'b0;
      err_q     <= 1'b0;
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      count_q   <= '0;
    end else begin
      if (slv_req_o && !slv_gnt_i) begin
        lock_q    <= 1'b1;
        lock_id_q <= winner;
      end else if (handshake) begin
        lock_q <= 1'b0;
        last_q <= winner;
      end

      if (handshake) begin
        wr_ptr_q <= ptr_inc(wr_ptr_q);
      end
      if (pop) begin
        rd_ptr_q <= ptr_inc(rd_ptr_q);
      end
      case ({handshake, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase

      if (slv_rvalid_i && empty) begin
        err_q <= 1'b1;
      end
    end
  end

  // NOTE: ID storage has no reset; entries are only read while count says they are valid.
  always_ff @(posedge clk_i) begin
    if (handshake) begin
      id_mem[wr_ptr_q] <= winner;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus random traffic
// compared each cycle against a queue-based reference model.
module tb_mem_port_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BW = DW / 8;
  localparam int MO = 2;

  logic          clk = 1'b0;
  logic          rst_i;
  logic          m0_req_i, m1_req_i, m0_we_i, m1_we_i;
  logic [AW-1:0] m0_addr_i, m1_addr_i;
  logic [BW-1:0] m0_be_i, m1_be_i;
  logic [DW-1:0] m0_wdata_i, m1_wdata_i;
  logic          m0_gnt_o, m1_gnt_o, m0_rvalid_o, m1_rvalid_o;
  logic [DW-1:0] m0_rdata_o, m1_rdata_o;
  logic          slv_req_o, slv_we_o, slv_gnt_i, slv_rvalid_i, err_o;
  logic [AW-1:0] slv_addr_o;
  logic [BW-1:0] slv_be_o;
  logic [DW-1:0] slv_wdata_o, slv_rdata_i;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_OUTSTANDING(MO)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .m0_req_i(m0_req_i), .m0_addr_i(m0_addr_i), .m0_we_i(m0_we_i), .m0_be_i(m0_be_i),
    .m0_wdata_i(m0_wdata_i), .m0_gnt_o(m0_gnt_o), .m0_rvalid_o(m0_rvalid_o), .m0_rdata_o(m0_rdata_o),
    .m1_req_i(m1_req_i), .m1_addr_i(m1_addr_i), .m1_we_i(m1_we_i), .m1_be_i(m1_be_i),
    .m1_wdata_i(m1_wdata_i), .m1_gnt_o(m1_gnt_o), .m1_rvalid_o(m1_rvalid_o), .m1_rdata_o(m1_rdata_o),
    .slv_req_o(slv_req_o), .slv_addr_o(slv_addr_o), .slv_we_o(slv_we_o), .slv_be_o(slv_be_o),
    .slv_wdata_o(slv_wdata_o), .slv_gnt_i(slv_gnt_i), .slv_rvalid_i(slv_rvalid_i),
    .slv_rdata_i(slv_rdata_i), .err_o(err_o)
  );

  // Staged stimulus, applied just after each rising edge.
  logic          s_rst;
  logic          s_req   [2];
  logic          s_we    [2];
  logic [AW-1:0] s_addr  [2];
  logic [BW-1:0] s_be    [2];
  logic [DW-1:0] s_wdata [2];
  logic          s_gnt, s_rv;
  logic [DW-1:0] s_rdata;

  // Reference model: outstanding grants as a queue of master IDs.
  bit q[$];
  bit last_id, locked, lock_id, m_err;
  int slave_pending;
  bit e_req, e_win;
  bit e_gnt [2];
  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic idle();
    s_rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      s_req[i] = 1'b0; s_we[i] = 1'b0; s_addr[i] = '0; s_be[i] = '0; s_wdata[i] = '0;
    end
    s_gnt = 1'b0; s_rv = 1'b0; s_rdata = '0;
  endtask

  task automatic set_master(input int i, input logic [AW-1:0] a);
    s_req[i] = 1'b1; s_addr[i] = a; s_we[i] = 1'(i); s_be[i] = 4'hf; s_wdata[i] = a ^ 32'h5a5a_0000;
  endtask

  task automatic step();
    bit had, hs;
    logic [127:0] exp_bus;
    @(posedge clk);
    #1;
    rst_i = s_rst;
    m0_req_i = s_req[0]; m0_addr_i = s_addr[0]; m0_we_i = s_we[0]; m0_be_i = s_be[0]; m0_wdata_i = s_wdata[0];
    m1_req_i = s_req[1]; m1_addr_i = s_addr[1]; m1_we_i = s_we[1]; m1_be_i = s_be[1]; m1_wdata_i = s_wdata[1];
    slv_gnt_i = s_gnt; slv_rvalid_i = s_rv; slv_rdata_i = s_rdata;
    #3;
    e_req = (s_req[0] || s_req[1]) && (q.size() != MO);
    if (locked)                     e_win = lock_id;
    else if (s_req[0] && !s_req[1]) e_win = 1'b0;
    else if (s_req[1] && !s_req[0]) e_win = 1'b1;
    else                            e_win = !last_id;
    hs = e_req && s_gnt;
    e_gnt[0] = hs && !e_win;
    e_gnt[1] = hs && e_win;
    had = (q.size() > 0);
    exp_bus = e_req ? {s_we[e_win], s_be[e_win], s_wdata[e_win], s_addr[e_win]} : '0;
    check("slv_req", slv_req_o, e_req);
    check("slv_bus", {slv_we_o, slv_be_o, slv_wdata_o, slv_addr_o}, exp_bus);
    check("m0_gnt", m0_gnt_o, e_gnt[0]);
    check("m1_gnt", m1_gnt_o, e_gnt[1]);
    check("m0_rvalid", m0_rvalid_o, s_rv && had && (q[0] == 1'b0));
    check("m1_rvalid", m1_rvalid_o, s_rv && had && (q[0] == 1'b1));
    check("m0_rdata", m0_rdata_o, s_rdata);
    check("m1_rdata", m1_rdata_o, s_rdata);
    check("err", err_o, m_err);
    // Advance the model to the state after the coming edge.
    if (s_rst) begin
      q.delete(); last_id = 1'b1; locked = 1'b0; m_err = 1'b0;
    end else begin
      if (e_req && !s_gnt) begin locked = 1'b1; lock_id = e_win; end
      if (s_rv) begin
        if (had) void'(q.pop_front());
        else     m_err = 1'b1;
      end
      if (hs) begin locked = 1'b0; last_id = e_win; q.push_back(e_win); end
    end
    if (s_rv && slave_pending > 0) slave_pending--;
    if (hs) slave_pending++;
  endtask

  task automatic drain();
    idle();
    for (int n = 0; n < 8 && slave_pending > 0; n++) begin
      s_rv = 1'b1; s_rdata = $urandom;
      step();
    end
    idle();
  endtask

  initial begin
    bit exp_id, first;
    idle();
    rst_i = 1'b1; m0_req_i = 0; m1_req_i = 0; slv_gnt_i = 0; slv_rvalid_i = 0;
    m0_addr_i = '0; m1_addr_i = '0; m0_we_i = 0; m1_we_i = 0; m0_be_i = '0; m1_be_i = '0;
    m0_wdata_i = '0; m1_wdata_i = '0; slv_rdata_i = '0;
    q.delete(); last_id = 1'b1; locked = 0; lock_id = 0; m_err = 0; slave_pending = 0;
    repeat (2) @(posedge clk);

    // Single read from master 0 with an immediate grant and a one-cycle response.
    idle(); step();
    set_master(0, 32'h80); s_gnt = 1'b1;
    step();
    check("t1_gnt", {m1_gnt_o, m0_gnt_o}, 2'b01);
    idle(); s_rv = 1'b1; s_rdata = 32'hdead_beef;
    step();
    check("t1_rvalid", {m1_rvalid_o, m0_rvalid_o}, 2'b01);
    check("t1_rdata", m0_rdata_o, 32'hdead_beef);

    // Both masters continuously, slave always ready: grants alternate starting with master 1.
    idle(); exp_id = 1'b1;
    for (int c = 0; c < 8; c++) begin
      set_master(0, 32'h1000 + c); set_master(1, 32'h2000 + c);
      s_gnt = 1'b1; s_rv = (slave_pending > 0); s_rdata = $urandom;
      step();
      check("t2_alt", {m1_gnt_o, m0_gnt_o}, exp_id ? 2'b10 : 2'b01);
      exp_id = !exp_id;
    end
    drain();

    // Slave stalls three cycles: winner and its address are held, the other master follows.
    exp_id = !last_id;
    set_master(0, 32'h3300); set_master(1, 32'h4400);
    for (int c = 0; c < 4; c++) begin
      s_gnt = (c == 3);
      step();
      check("t3_addr", slv_addr_o, exp_id ? 32'h4400 : 32'h3300);
    end
    check("t3_gnt", {m1_gnt_o, m0_gnt_o}, exp_id ? 2'b10 : 2'b01);
    step();
    check("t3_next", {m1_gnt_o, m0_gnt_o}, exp_id ? 2'b01 : 2'b10);
    drain();

    // FIFO fills after two unanswered grants; request resumes the cycle after a pop.
    set_master(0, 32'h50); set_master(1, 32'h60); s_gnt = 1'b1;
    step(); first = e_win;
    step();
    step();
    check("t4_full", slv_req_o, 1'b0);
    s_rv = 1'b1; s_rdata = 32'h1234_5678;
    step();
    check("t4_full_pop", slv_req_o, 1'b0);
    check("t4_route", {m1_rvalid_o, m0_rvalid_o}, first ? 2'b10 : 2'b01);
    s_rv = 1'b0;
    step();
    check("t4_resume", slv_req_o, 1'b1);
    drain();

    // Response with nothing outstanding sets the sticky error.
    s_rv = 1'b1; step();
    check("t5_norv", {m1_rvalid_o, m0_rvalid_o, err_o}, 3'b000);
    idle(); step();
    check("t5_err", err_o, 1'b1);
    step();
    check("t5_sticky", err_o, 1'b1);

    // Reset with two outstanding drops them; a stale response then flags an error.
    s_rst = 1'b1; step(); idle();
    set_master(0, 32'h70); set_master(1, 32'h74); s_gnt = 1'b1;
    step(); step();
    idle(); s_rst = 1'b1; step(); idle();
    step();
    check("t6_idle", {slv_req_o, m0_gnt_o, m1_gnt_o, m0_rvalid_o, m1_rvalid_o, err_o, slv_addr_o}, '0);
    set_master(0, 32'h78); set_master(1, 32'h7c); s_gnt = 1'b1;
    step();
    check("t6_first", {m1_gnt_o, m0_gnt_o}, 2'b01);
    idle(); s_rv = 1'b1; step(); // answers the new grant
    s_rv = 1'b1; step();         // stale: nothing outstanding in the arbiter
    idle(); step();
    check("t6_stale_err", err_o, 1'b1);
    s_rst = 1'b1; step(); idle();

    // Random traffic with occasional resets; masters hold requests until granted.
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < 2; i++) begin
        if (!s_req[i] && $urandom_range(2) == 0) begin
          s_req[i] = 1'b1; s_addr[i] = $urandom; s_we[i] = 1'($urandom_range(1));
          s_be[i] = BW'($urandom); s_wdata[i] = $urandom;
        end
      end
      s_gnt = ($urandom_range(9) < 6);
      s_rv = (slave_pending > 0) && ($urandom_range(1) == 1);
      s_rdata = $urandom;
      s_rst = ($urandom_range(199) == 0);
      if (s_rst) begin
        s_req[0] = 1'b0; s_req[1] = 1'b0; s_gnt = 1'b0; s_rv = 1'b0;
      end
      step();
      for (int i = 0; i < 2; i++) if (e_gnt[i]) s_req[i] = 1'b0;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
